mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//   Iterative multiply/divide sequencer for the E stage. Accepts one M-extension op (one-hot mul..remu
//   slice of alu_info) from decode over valid/ready, runs a radix-2 shift-add/restoring-subtract loop,
//   returns a XLEN result with its rd. Owns the single shared MDU datapath; stalls D while busy.
// PARAMETERS
//   XLEN     64   operand/result width; loop count = XLEN iterations
//   RS_W     5    register index width (matches ysyx_23060251_rs_bus)
// PORTS
//   clk          in   1      core clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   in_valid_i   in   1      op valid from D
//   in_ready_o   out  1      MDU can accept (IDLE only)
//   op_i         in   8      one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}
//   src1_i       in   XLEN   rs1 value
//   src2_i       in   XLEN   rs2 value
//   rd_i         in   RS_W   destination register
//   flush_i      in   1      kill in-flight op (redirect/exception)
//   out_valid_o  out  1      result valid to W/forwarding
//   out_ready_i  in   1      consumer accepts result
//   result_o     out  XLEN   final result
//   rd_o         out  RS_W   destination of result
//   busy_o       out  1      state != IDLE (hazard unit interlock on rd_o)
// BEHAVIOUR
//   Reset: state=IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, result_o=0, rd_o=0, counter=0.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: accept when in_valid_i&in_ready_o; latch op, rd, |operands| and sign flags; op_i==0 ignored.
//   CALC: one iteration/cycle, counter 0..XLEN-1; leave to DONE when counter==XLEN-1.
//   DONE: out_valid_o=1, held stable until out_ready_i; on handshake -> IDLE (no same-cycle accept).
//   Latency accept->out_valid_o = XLEN+1 cycles (65 at default).
//   Mul: 2*XLEN product of magnitudes; negate if signs differ (mulh: both signed, mulhsu: src1 only).
//     mul -> low XLEN; mulh/mulhsu/mulhu -> high XLEN.
//   Div: restoring on magnitudes; quotient sign = s1^s2, remainder sign = s1 (signed ops only).
//   Div by zero: q = all ones, r = src1. Signed overflow (src1=MIN, src2=-1): q = MIN, r = 0.
//     Special cases still take full latency unless YSYX_23060251_MDU_EARLY_EN.
//   flush_i: any state -> IDLE next cycle, out_valid_o=0; flush has priority over accept and over
//     out_ready_i. flush in IDLE with in_valid_i: op not accepted.
//   Reset mid-operation: immediate return to reset values, no result emitted.
// CONFIGURATION
//   YSYX_23060251_MDU_EARLY_EN defined: div-by-zero, signed overflow, and either operand zero
//     (mul*/div*/rem*) skip CALC: IDLE -> DONE, latency 1 cycle, same result values.
//   Undefined: every op takes XLEN+1 cycles.
// STRUCTURE
//   Package ysyx_23060251_mdu_pkg: mdu_state_e {IDLE,CALC,DONE}; op index localparams
//     (MDU_MUL..MDU_REMU); XLEN_MIN constant.
//   Sub-module mdu_iter_dp: shift registers, adder/subtractor, one-step update; FSM and sign/
//     special-case fixup stay in mdu_seq.
// TESTING
//   mul 7*-3 (0x7, 0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid_o at cycle 65.
//   mulhu 0xFFFF_FFFF_FFFF_FFFF*2 -> 0x1; mulh -1*-1 -> 0x0; mulhsu -1*2 -> 0xFFFF_FFFF_FFFF_FFFF.
//   div -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; rem -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; divu 100/7 -> 14, remu -> 2.
//   div 5/0 -> all ones, rem 5/0 -> 5; div MIN/-1 -> MIN, rem -> 0 (1 cycle with _EARLY_EN, 65 without).
//   out_ready_i low 10 cycles in DONE -> result_o/rd_o stable, in_ready_o=0; then handshake -> IDLE.
//   flush_i at CALC counter 30 -> IDLE next cycle, no out_valid_o; rst_n low mid-CALC -> reset values.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op indices select bits of the one-hot op vector {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}.
package ysyx_23060251_mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam int MDU_MUL    = 0;
    localparam int MDU_MULH   = 1;
    localparam int MDU_MULHSU = 2;
    localparam int MDU_MULHU  = 3;
    localparam int MDU_DIV    = 4;
    localparam int MDU_DIVU   = 5;
    localparam int MDU_REM    = 6;
    localparam int MDU_REMU   = 7;

    localparam int          MDU_XLEN = 64;
    localparam logic [63:0] XLEN_MIN = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/mdu_iter_dp.sv
// Radix-2 datapath: shift-add multiply or restoring divide on unsigned magnitudes, one step per i_step.
// o_hi_nxt/o_lo_nxt expose the post-step values so the caller can capture the final step directly.
module mdu_iter_dp #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi_nxt,
    output logic [XLEN-1:0] o_lo_nxt
);
    logic [XLEN-1:0] r_hi, r_lo, r_b;
    logic [XLEN:0]   w_lhs, w_rhs, w_sum;
    logic            w_qbit;

    // One shared adder: add multiplicand for mul, subtract divisor (two's complement) for div.
    always_comb begin
        if (i_div) begin
            w_lhs = {r_hi, r_lo[XLEN-1]};
            w_rhs = ~{1'b0, r_b};
        end else begin
            w_lhs = {1'b0, r_hi};
            w_rhs = r_lo[0] ? {1'b0, r_b} : '0;
        end
    end

    assign w_sum  = w_lhs + w_rhs + {{XLEN{1'b0}}, i_div};
    assign w_qbit = ~w_sum[XLEN];

    always_comb begin
        if (i_div) begin
            o_hi_nxt = w_qbit ? w_sum[XLEN-1:0] : w_lhs[XLEN-1:0];
            o_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
        end else begin
            o_hi_nxt = w_sum[XLEN:1];
            o_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_step) begin
            r_hi <= o_hi_nxt;
            r_lo <= o_lo_nxt;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: IDLE -> CALC (XLEN steps) -> DONE; result held until out_ready_i.
// Define YSYX_23060251_MDU_EARLY_EN to finish zero-operand, div-by-zero and overflow ops in 1 cycle.
module mdu_seq
    import ysyx_23060251_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN,
    parameter int RS_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [7:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [RS_W-1:0] rd_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [RS_W-1:0] rd_o,
    output logic            busy_o
);
    localparam int              CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_op;
    logic             r_div, r_neg, r_rneg, r_div0;

    logic            w_accept, w_s1, w_s2, w_op_div;
    logic [XLEN-1:0] w_a, w_b, w_hi_nxt, w_lo_nxt, w_quo, w_rem, w_final;
    logic [2*XLEN-1:0] w_prod, w_prod_f;

    assign w_accept = (r_state == IDLE) && in_valid_i && (|op_i);
    assign w_op_div = |op_i[MDU_REMU:MDU_DIV];
    assign w_s1 = src1_i[XLEN-1] & (op_i[MDU_MULH] | op_i[MDU_MULHSU] | op_i[MDU_DIV] | op_i[MDU_REM]);
    assign w_s2 = src2_i[XLEN-1] & (op_i[MDU_MULH] | op_i[MDU_DIV] | op_i[MDU_REM]);
    assign w_a  = w_s1 ? (~src1_i + 1'b1) : src1_i;
    assign w_b  = w_s2 ? (~src2_i + 1'b1) : src2_i;

    mdu_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (r_state == CALC),
        .i_div    (r_div),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // Magnitude results fixed up by sign; the MIN/-1 case falls out naturally, div-by-zero does not.
    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_f = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = r_div0 ? '1 : (r_neg ? (~w_lo_nxt + 1'b1) : w_lo_nxt);
    assign w_rem    = r_rneg ? (~w_hi_nxt + 1'b1) : w_hi_nxt;

    always_comb begin
        w_final = w_prod_f[2*XLEN-1:XLEN];
        if (r_op[MDU_MUL])                        w_final = w_prod_f[XLEN-1:0];
        else if (r_op[MDU_DIV] | r_op[MDU_DIVU])  w_final = w_quo;
        else if (r_op[MDU_REM] | r_op[MDU_REMU])  w_final = w_rem;
    end

`ifdef YSYX_23060251_MDU_EARLY_EN
    localparam logic [XLEN-1:0] L_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic            w_z1, w_z2, w_ovf, w_early;
    logic [XLEN-1:0] w_early_res;

    assign w_z1    = (src1_i == '0);
    assign w_z2    = (src2_i == '0);
    assign w_ovf   = (op_i[MDU_DIV] | op_i[MDU_REM]) && (src1_i == L_MIN) && (src2_i == '1);
    assign w_early = w_z1 | w_z2 | w_ovf;

    always_comb begin
        w_early_res = '0;
        if (op_i[MDU_DIV] | op_i[MDU_DIVU])
            w_early_res = w_z2 ? '1 : (w_ovf ? L_MIN : '0);
        else if (op_i[MDU_REM] | op_i[MDU_REMU])
            w_early_res = w_z2 ? src1_i : '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_div       <= 1'b0;
            r_neg       <= 1'b0;
            r_rneg      <= 1'b0;
            r_div0      <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            result_o    <= '0;
            rd_o        <= '0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op       <= op_i;
                    r_div      <= w_op_div;
                    r_neg      <= w_s1 ^ w_s2;
                    r_rneg     <= w_s1;
                    r_div0     <= (src2_i == '0);
                    rd_o       <= rd_i;
                    r_cnt      <= '0;
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b1;
                    r_state    <= CALC;
`ifdef YSYX_23060251_MDU_EARLY_EN
                    if (w_early) begin
                        r_state     <= DONE;
                        result_o    <= w_early_res;
                        out_valid_o <= 1'b1;
                    end
`endif
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= DONE;
                        result_o    <= w_final;
                        out_valid_o <= 1'b1;
                    end
                end
                DONE: if (out_ready_i) begin
                    r_state     <= IDLE;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic vectors, latency, backpressure, flush and reset.
// Special-case latency expectation follows YSYX_23060251_MDU_EARLY_EN.
module tb_mdu_seq;
    import ysyx_23060251_mdu_pkg::*;

    localparam int XLEN = 64;
    localparam int RS_W = 5;
    localparam int NORM_LAT = XLEN + 1;
`ifdef YSYX_23060251_MDU_EARLY_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = XLEN + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [7:0]      op_i = '0;
    logic [XLEN-1:0] src1_i = '0;
    logic [XLEN-1:0] src2_i = '0;
    logic [RS_W-1:0] rd_i = '0;
    logic            flush_i = 1'b0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic [RS_W-1:0] rd_o;
    logic            busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    mdu_seq #(.XLEN(XLEN), .RS_W(RS_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .rd_i        (rd_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .rd_o        (rd_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        in_valid_i = 1'b1; op_i = op; src1_i = a; src2_i = b; rd_i = rd;
        @(posedge clk); #1;
        in_valid_i = 1'b0; op_i = '0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        chk({tag, "_idle_rdy"}, 64'(in_ready_o), 64'd1);
        chk({tag, "_idle_vld"}, 64'(out_valid_o), 64'd0);
    endtask

    task automatic watch_no_out(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    typedef struct {
        string       name;
        int          op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"mul",       MDU_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, NORM_LAT});
        vecs.push_back('{"mulhu",     MDU_MULHU,  '1,    64'd2,  64'h1,  NORM_LAT});
        vecs.push_back('{"mulh",      MDU_MULH,   '1,    '1,     64'h0,  NORM_LAT});
        vecs.push_back('{"mulhsu",    MDU_MULHSU, '1,    64'd2,  '1,     NORM_LAT});
        vecs.push_back('{"div",       MDU_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, NORM_LAT});
        vecs.push_back('{"rem",       MDU_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, NORM_LAT});
        vecs.push_back('{"divu",      MDU_DIVU,   64'd100, 64'd7, 64'd14, NORM_LAT});
        vecs.push_back('{"remu",      MDU_REMU,   64'd100, 64'd7, 64'd2,  NORM_LAT});
        vecs.push_back('{"div_by0",   MDU_DIV,    64'd5, 64'd0, '1,    SP_LAT});
        vecs.push_back('{"rem_by0",   MDU_REM,    64'd5, 64'd0, 64'd5, SP_LAT});
        vecs.push_back('{"div_ovf",   MDU_DIV,    XLEN_MIN, '1, XLEN_MIN, SP_LAT});
        vecs.push_back('{"rem_ovf",   MDU_REM,    XLEN_MIN, '1, 64'd0, SP_LAT});

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_vld",  64'(out_valid_o), 64'd0);
        chk("rst_busy",     64'(busy_o), 64'd0);
        chk("rst_result",   result_o, 64'd0);
        chk("rst_rd",       64'(rd_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(8'(1 << vecs[i].op), vecs[i].a, vecs[i].b, 5'(i + 1));
            wait_out(vecs[i].name, vecs[i].lat);
            chk({vecs[i].name, "_res"}, result_o, vecs[i].exp);
            chk({vecs[i].name, "_rd"},  64'(rd_o), 64'(i + 1));
            retire(vecs[i].name);
        end

        // Busy interlock and DONE backpressure
        issue(8'(1 << MDU_MUL), 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
        chk("calc_in_ready", 64'(in_ready_o), 64'd0);
        chk("calc_busy",     64'(busy_o), 64'd1);
        wait_out("bp", NORM_LAT);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_result", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
            chk("bp_rd",     64'(rd_o), 64'd9);
            chk("bp_vld",    64'(out_valid_o), 64'd1);
            chk("bp_in_rdy", 64'(in_ready_o), 64'd0);
        end
        retire("bp");

        // Flush at counter 30
        issue(8'(1 << MDU_DIVU), 64'd100, 64'd7, 5'd3);
        repeat (30) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_vld",    64'(out_valid_o), 64'd0);
        chk("flush_busy",   64'(busy_o), 64'd0);
        chk("flush_in_rdy", 64'(in_ready_o), 64'd1);
        watch_no_out("flush_no_out", 80);

        // Flush beats accept in IDLE; zero op is ignored
        @(negedge clk);
        in_valid_i = 1'b1; op_i = 8'(1 << MDU_MUL); flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; op_i = '0;
        chk("flush_idle_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("zero_op_busy", 64'(busy_o), 64'd0);

        // Reset mid-CALC
        issue(8'(1 << MDU_MULHU), '1, 64'd2, 5'd7);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   64'(busy_o), 64'd0);
        chk("mid_rst_vld",    64'(out_valid_o), 64'd0);
        chk("mid_rst_in_rdy", 64'(in_ready_o), 64'd1);
        chk("mid_rst_result", result_o, 64'd0);
        chk("mid_rst_rd",     64'(rd_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_out("mid_rst_no_out", 80);

        // Still functional afterwards
        issue(8'(1 << MDU_REMU), 64'd100, 64'd7, 5'd31);
        wait_out("post_rst", NORM_LAT);
        chk("post_rst_res", result_o, 64'd2);
        retire("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
